sync_fifo_flags: RTL
====================

# sync_fifo_flags

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, and an occupancy count. It also adds sticky overflow and underflow error flags and an optional first-word-fall-through read mode. It buffers data between a producer and a consumer in the same clock domain and is the FIFO all new datapath blocks instantiate.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- wr_en  in  1  write request
- data_in  in  DATA_W  write data, sampled when a write is accepted
- rd_en  in  1  read request (a pop in FWFT mode)
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Storage is an array of DEPTH words with rd_ptr and wr_ptr, each $clog2(DEPTH) bits.
  - Pointers wrap from DEPTH-1 to 0 naturally.
  - count is kept separately; full and empty are never derived from pointer equality.
- A read is accepted when rd_acc = rd_en && !empty.
- A write is accepted when wr_acc = wr_en && (!full || rd_en).
  - When the FIFO is full, a simultaneous read frees a slot, so both operations are accepted and count is unchanged.
- When empty, a simultaneous wr_en and rd_en gives: write accepted, read rejected, underflow set, count becomes 1.
- count moves by +1 on a write only, -1 on a read only, and 0 when both or neither are accepted. It never exceeds DEPTH and never goes below 0.
- A dropped write (wr_en && full && !rd_en) leaves memory, pointers and count unchanged and sets overflow.
- A rejected read (rd_en && empty) leaves data_out holding its last value and sets underflow.
- overflow and underflow stay set until clr_err or reset.
  - If clr_err coincides with a new error event in the same cycle, the flag is set: the set wins.
- full, empty, almost_full and almost_empty are decoded from the registered count only, so they are glitch-free and consistent with count in every cycle.
- Reset values: data_out=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_ptr=wr_ptr=0. Memory contents are not reset.
- An assertion of rst_n mid-operation discards all contents immediately, asynchronously. The first write after deassertion lands at entry 0.

## Timing
- A write accepted at edge N makes count, empty and the almost flags reflect it from edge N.
- Standard mode:
  - A read accepted at edge N registers the head word into data_out at edge N. Read latency is one clock from the rd_en sample.
  - data_out holds until the next accepted read.
- Minimum latency from a write into an empty FIFO to the data being readable:
  - empty falls after the write edge.
  - rd_en is sampled at the next edge.
  - data_out is valid after that edge.
- Back-to-back reads and writes are sustained at one per clock each.

## Configuration
- SYNC_FIFO_FWFT_EN defined (first-word-fall-through):
  - data_out = mem[rd_ptr] whenever empty==0, with no registered read stage. rd_en acts as an acknowledge/pop.
  - Data written into an empty FIFO appears on data_out in the cycle after the write edge, together with empty falling.
  - While empty, data_out is undefined-but-stable (last head); benches must not check it.
- Not defined: standard registered-read behaviour as above.
- All flag, count and error behaviour is identical in both modes.

## Test plan
- Reset, then idle → data_out=0, empty=1, almost_empty=1, full=0, count=0, overflow=underflow=0.
- DEPTH=16, AF=14, AE=2; write 0x01..0x10, then read 16 → data returned in order 0x01..0x10, each one clock after rd_en (standard mode):
  - almost_empty deasserts at count 3.
  - almost_full asserts at count 14.
  - full asserts at count 16.
- At full, one cycle of wr_en=1 (0xAA) with rd_en=0 → overflow=1, count stays 16, and 0xAA is never read back. Then clr_err=1 for one cycle → overflow=0.
- At full, wr_en=rd_en=1 with data 0x55 → count stays 16, the oldest word is read, and 0x55 emerges as the 16th subsequent read.
- At empty, wr_en=rd_en=1 with data 0x33 → underflow=1, count=1, and 0x33 is read next. Pulsing rst_n low mid-stream with count=5 → count=0 and empty=1 immediately.
- Build with SYNC_FIFO_FWFT_EN: write 0x77 into an empty FIFO → data_out=0x77 on the cycle empty falls, before any rd_en. A single rd_en pops it and empty returns to 1.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if
// Bundles the producer/consumer side of sync_fifo_flags into one interface.
//   master : the block using the FIFO (drives wr_en, data_in, rd_en, clr_err)
//   slave  : the FIFO itself (drives data_out, status flags, count, error flags)
// Parameters DATA_W and DEPTH must match those of the attached sync_fifo_flags.
interface sync_fifo_flags_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic                     wr_en;
  logic [DATA_W-1:0]        data_in;
  logic                     rd_en;
  logic                     clr_err;
  logic [DATA_W-1:0]        data_out;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow error flags.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset; clears pointers, count, flags, data_out
//   fifo  : sync_fifo_flags_if.slave
//           in : wr_en, data_in, rd_en, clr_err
//           out: data_out, full, empty, almost_full, almost_empty, count,
//                overflow, underflow
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word combinationally, rd_en pops). Without it,
// data_out is registered and loads the head word on each accepted read.
module sync_fifo_flags #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_flags_if.slave fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic              is_full;
  logic              is_empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_q;
  logic              unf_q;

  // Status is decoded from the registered count only, never from pointers.
  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);

  // A read on a full FIFO frees a slot in the same cycle, so the write may
  // proceed alongside it.
  assign rd_acc = fifo.rd_en && !is_empty;
  assign wr_acc = fifo.wr_en && (!is_full || fifo.rd_en);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= fifo.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (fifo.wr_en && is_full && !fifo.rd_en) ovf_q <= 1'b1;
      else if (fifo.clr_err)                    ovf_q <= 1'b0;
      if (fifo.rd_en && is_empty)               unf_q <= 1'b1;
      else if (fifo.clr_err)                    unf_q <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as it is written; undefined while empty.
  assign fifo.data_out = mem[rd_ptr];
`else
  logic [DATA_W-1:0] dout_q;

  // Holds its value across rejected reads and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout_q <= '0;
    else if (rd_acc) dout_q <= mem[rd_ptr];
  end

  assign fifo.data_out = dout_q;
`endif

  assign fifo.count        = cnt;
  assign fifo.full         = is_full;
  assign fifo.empty        = is_empty;
  assign fifo.almost_full  = (cnt >= CW'(AF_THRESH));
  assign fifo.almost_empty = (cnt <= CW'(AE_THRESH));
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule
